// File: rtl/mips_pkg.sv
// Shared MIPS-style encodings for the PC sequencer: branch conditions, FSM states, instruction size.
package mips_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned COND_W     = 3;
    localparam int unsigned STATE_W    = 2;
    localparam int unsigned INDEX_W    = 26;

    // Branch condition encodings (11x = never taken)
    localparam logic [COND_W-1:0] COND_EQ  = 3'b000;
    localparam logic [COND_W-1:0] COND_NE  = 3'b001;
    localparam logic [COND_W-1:0] COND_LEZ = 3'b010;
    localparam logic [COND_W-1:0] COND_GTZ = 3'b011;
    localparam logic [COND_W-1:0] COND_LTZ = 3'b100;
    localparam logic [COND_W-1:0] COND_GEZ = 3'b101;

    // Sequencer FSM states
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
    localparam logic [STATE_W-1:0] ST_EXEC  = 2'd2;
    localparam logic [STATE_W-1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC calculation: branch condition evaluation, target adders and priority select.
module pc_target_calc
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic               branch,
    input  logic [COND_W-1:0]  branch_cond,
    input  logic               alu_zero,
    input  logic               alu_neg,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic [ADDR_W-1:0]  imm_offset,
    input  logic [INDEX_W-1:0] jump_index,
    input  logic [ADDR_W-1:0]  reg_target,
    output logic [ADDR_W-1:0]  pc4_c,
    output logic [ADDR_W-1:0]  next_pc_c,
    output logic               misaligned_c
);

    logic              taken;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;

    // Branch condition from ALU flags
    always_comb begin
        taken = 1'b0;
        case (branch_cond)
            COND_EQ:  taken = alu_zero;
            COND_NE:  taken = !alu_zero;
            COND_LEZ: taken = alu_neg || alu_zero;
            COND_GTZ: taken = !alu_neg && !alu_zero;
            COND_LTZ: taken = alu_neg;
            COND_GEZ: taken = !alu_neg;
            default:  taken = 1'b0;
        endcase
    end

    // Candidate targets; all sums wrap modulo 2^ADDR_W
    always_comb begin
        pc4_c        = pc + ADDR_W'(INST_BYTES);
        branch_tgt   = pc4_c + (imm_offset << 2);
        jump_tgt     = {pc4_c[ADDR_W-1:28], jump_index, 2'b00};
        misaligned_c = jump_reg && (reg_target[1:0] != 2'b00);
    end

    // Priority select: jump_reg > jump > taken branch > sequential
    always_comb begin
        next_pc_c = pc4_c;
        if (jump_reg) begin
            next_pc_c = reg_target;
        end else if (jump) begin
            next_pc_c = jump_tgt;
        end else if (branch && taken) begin
            next_pc_c = branch_tgt;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the PC, fetches over valid/ready, waits for retire, commits next PC.
// Optional feature macro PC_EXC_EN: adds exc_req/epc and redirects faults to EXC_VECTOR.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
`ifdef PC_EXC_EN
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0180),
`endif
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_0000)
) (
    input  logic               clk,
    input  logic               rst_,
    output logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    input  logic               inst_done,
    input  logic               branch,
    input  logic [COND_W-1:0]  branch_cond,
    input  logic               alu_zero,
    input  logic               alu_neg,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic [ADDR_W-1:0]  imm_offset,
    input  logic [INDEX_W-1:0] jump_index,
    input  logic [ADDR_W-1:0]  reg_target,
    output logic [ADDR_W-1:0]  link_addr,
    output logic               misaligned_err,
`ifdef PC_EXC_EN
    input  logic               exc_req,
    output logic [ADDR_W-1:0]  epc,
`endif
    output logic               halted
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic               err_next;
    logic [ADDR_W-1:0]  pc4_c;
    logic [ADDR_W-1:0]  next_pc_c;
    logic               misaligned_c;
`ifdef PC_EXC_EN
    logic [ADDR_W-1:0]  epc_next;
`endif

    pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
        .pc           (pc),
        .branch       (branch),
        .branch_cond  (branch_cond),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .imm_offset   (imm_offset),
        .jump_index   (jump_index),
        .reg_target   (reg_target),
        .pc4_c        (pc4_c),
        .next_pc_c    (next_pc_c),
        .misaligned_c (misaligned_c)
    );

    assign fetch_addr = pc;
    assign link_addr  = pc4_c;

    // Next-state, next-PC and fault decode
    always_comb begin
        state_next = state;
        pc_next    = pc;
        err_next   = 1'b0;
`ifdef PC_EXC_EN
        epc_next   = epc;
`endif
        case (state)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                if (fetch_ready) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef PC_EXC_EN
                if (exc_req) begin
                    epc_next   = pc;
                    pc_next    = EXC_VECTOR;
                    state_next = ST_FETCH;
                end else
`endif
                if (inst_done) begin
                    if (misaligned_c) begin
                        err_next   = 1'b1;
`ifdef PC_EXC_EN
                        epc_next   = pc;
                        pc_next    = EXC_VECTOR;
                        state_next = ST_FETCH;
`else
                        state_next = ST_HALT;
`endif
                    end else begin
                        pc_next    = next_pc_c;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // State, PC and registered status outputs
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state          <= ST_IDLE;
            pc             <= RESET_VECTOR;
            fetch_valid    <= 1'b0;
            misaligned_err <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            fetch_valid    <= (state_next == ST_FETCH);
            misaligned_err <= err_next;
            halted         <= (state_next == ST_HALT);
        end
    end

`ifdef PC_EXC_EN
    // Exception PC capture
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            epc <= '0;
        end else begin
            epc <= epc_next;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expectations, monitor compares at negedge.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 32;

    logic              clk;
    logic              rst_;
    logic [31:0]       fetch_addr;
    logic              fetch_valid;
    logic              fetch_ready;
    logic              inst_done;
    logic              branch;
    logic [2:0]        branch_cond;
    logic              alu_zero;
    logic              alu_neg;
    logic              jump;
    logic              jump_reg;
    logic [31:0]       imm_offset;
    logic [25:0]       jump_index;
    logic [31:0]       reg_target;
    logic [31:0]       link_addr;
    logic              misaligned_err;
    logic              halted;
`ifdef PC_EXC_EN
    logic              exc_req;
    logic [31:0]       epc;
`endif

    pc_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_           (rst_),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .inst_done      (inst_done),
        .branch         (branch),
        .branch_cond    (branch_cond),
        .alu_zero       (alu_zero),
        .alu_neg        (alu_neg),
        .jump           (jump),
        .jump_reg       (jump_reg),
        .imm_offset     (imm_offset),
        .jump_index     (jump_index),
        .reg_target     (reg_target),
        .link_addr      (link_addr),
        .misaligned_err (misaligned_err),
`ifdef PC_EXC_EN
        .exc_req        (exc_req),
        .epc            (epc),
`endif
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard queues
    logic [31:0] exp_fetch_q[$];
    string       chk_name_q[$];
    logic [31:0] chk_act_q[$];
    logic [31:0] chk_exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] cur_pc;

    task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_name_q.push_back(name);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(exp);
    endtask

    // Monitor: drains posted checks and compares every fetch handshake
    initial begin
        string       nm;
        logic [31:0] a;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            while (chk_name_q.size() > 0) begin
                nm = chk_name_q.pop_front();
                a  = chk_act_q.pop_front();
                e  = chk_exp_q.pop_front();
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", nm, a, e);
                end
            end
            if (rst_ && fetch_valid && fetch_ready) begin
                n_vec++;
                if (exp_fetch_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_fetch: got %h expected none", fetch_addr);
                end else begin
                    e = exp_fetch_q.pop_front();
                    if (fetch_addr !== e) begin
                        n_err++;
                        $display("FAIL fetch_addr: got %h expected %h", fetch_addr, e);
                    end
                end
            end
        end
    end

    task automatic clear_ctrl();
        inst_done   = 1'b0;
        branch      = 1'b0;
        branch_cond = 3'b000;
        alu_zero    = 1'b0;
        alu_neg     = 1'b0;
        jump        = 1'b0;
        jump_reg    = 1'b0;
        imm_offset  = 32'h0;
        jump_index  = 26'h0;
        reg_target  = 32'h0;
    endtask

    // Wait (bounded) for a fetch request, optionally stall, then accept it
    task automatic do_fetch(input int stall);
        int n = 0;
        while (!fetch_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!fetch_valid) post("fetch_valid_timeout", 32'(fetch_valid), 32'h1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            post("stall_valid", 32'(fetch_valid), 32'h1);
            post("stall_addr", fetch_addr, cur_pc);
        end
        fetch_ready = 1'b1;
        @(posedge clk); #1;
        fetch_ready = 1'b0;
    endtask

    // Retire the current instruction with the given control inputs
    task automatic retire(input int delay, input logic br, input logic [2:0] cond,
                          input logic z, input logic n, input logic j, input logic jr,
                          input logic [31:0] imm, input logic [25:0] idx,
                          input logic [31:0] rt, input logic [31:0] exp_next,
                          input logic push_fetch);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            post("exec_valid_low", 32'(fetch_valid), 32'h0);
        end
        post("link_addr", link_addr, cur_pc + 32'd4);
        branch      = br;
        branch_cond = cond;
        alu_zero    = z;
        alu_neg     = n;
        jump        = j;
        jump_reg    = jr;
        imm_offset  = imm;
        jump_index  = idx;
        reg_target  = rt;
        inst_done   = 1'b1;
        if (push_fetch) exp_fetch_q.push_back(exp_next);
        @(posedge clk); #1;
        clear_ctrl();
        if (push_fetch) cur_pc = exp_next;
    endtask

    task automatic instr(input int stall, input int delay, input logic br, input logic [2:0] cond,
                         input logic z, input logic n, input logic j, input logic jr,
                         input logic [31:0] imm, input logic [25:0] idx,
                         input logic [31:0] rt, input logic [31:0] exp_next);
        do_fetch(stall);
        retire(delay, br, cond, z, n, j, jr, imm, idx, rt, exp_next, 1'b1);
    endtask

    task automatic jr_to(input logic [31:0] tgt);
        instr(0, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, tgt, tgt);
    endtask

    initial begin
        int n;
        clear_ctrl();
        fetch_ready = 1'b0;
`ifdef PC_EXC_EN
        exc_req = 1'b0;
`endif
        rst_   = 1'b1;
        cur_pc = 32'h0;
        #1 rst_ = 1'b0;
        #2;
        post("rst_fetch_addr", fetch_addr, 32'h0);
        post("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        post("rst_halted", 32'(halted), 32'h0);
        post("rst_misaligned", 32'(misaligned_err), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_ = 1'b1;
        exp_fetch_q.push_back(32'h0);
        @(posedge clk); #1;
        post("first_fetch_valid", 32'(fetch_valid), 32'h1);

        // Handshake stall and sequential retire
        jr_to(32'h100);
        instr(3, 2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h104);

        // Conditional branches
        jr_to(32'h100);
        instr(0, 0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'h0FC);
        jr_to(32'h100);
        instr(0, 0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'h104);
        jr_to(32'h100);
        instr(0, 0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 32'h0FC);
        instr(0, 0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 26'h0, 32'h0, 32'h110);
        instr(0, 0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 26'h0, 32'h0, 32'h114);
        instr(0, 0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 26'h0, 32'h0, 32'h11C);
        instr(0, 0, 1'b1, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 26'h0, 32'h0, 32'h120);
        instr(0, 0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 26'h0, 32'h0, 32'h124);

        // Jumps and priority
        jr_to(32'h1000_0000);
        instr(0, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 26'h40, 32'h0, 32'h1000_0100);
        instr(0, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 26'h40, 32'h200, 32'h200);
        instr(0, 0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 26'h10, 32'h0, 32'h40);

        // Wrap at top of address space
        jr_to(32'hFFFF_FFFC);
        instr(0, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0);

        // Reset asserted while in EXEC
        jr_to(32'h300);
        do_fetch(0);
        rst_ = 1'b0;
        #1;
        post("midrst_fetch_addr", fetch_addr, 32'h0);
        post("midrst_fetch_valid", 32'(fetch_valid), 32'h0);
        @(posedge clk); #1;
        rst_   = 1'b1;
        cur_pc = 32'h0;
        exp_fetch_q.push_back(32'h0);

        // Misaligned JR
        jr_to(32'h400);
        do_fetch(0);
`ifdef PC_EXC_EN
        retire(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h202, 32'h180, 1'b1);
        post("err_pulse", 32'(misaligned_err), 32'h1);
        post("err_halted", 32'(halted), 32'h0);
        post("err_fetch_addr", fetch_addr, 32'h180);
        post("err_epc", epc, 32'h400);
        @(posedge clk); #1;
        post("err_pulse_end", 32'(misaligned_err), 32'h0);
        do_fetch(0);
`else
        retire(0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h202, 32'h0, 1'b0);
        post("err_pulse", 32'(misaligned_err), 32'h1);
        post("err_halted", 32'(halted), 32'h1);
        post("err_fetch_valid", 32'(fetch_valid), 32'h0);
        post("err_fetch_addr", fetch_addr, 32'h400);
        fetch_ready = 1'b1;
        @(posedge clk); #1;
        post("err_pulse_end", 32'(misaligned_err), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        post("halt_held", 32'(halted), 32'h1);
        post("halt_valid_low", 32'(fetch_valid), 32'h0);
        fetch_ready = 1'b0;
`endif

        @(posedge clk); #1;
        post("fetch_queue_drained", 32'(exp_fetch_q.size()), 32'h0);
        n = 0;
        while (chk_name_q.size() > 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
